// File: rtl/memory_responder.sv
// memory_responder
//   Single-port, word-addressed data memory acting as the responder end of the
//   CPU memory bus. After reset it sweeps every location to CLEAR_VALUE (one
//   word per cycle) while holding busy high. Once ready, it serves CPU writes,
//   accepts preload words over a valid/ready port when the CPU is not writing,
//   and returns read data through a READ_LATENCY-deep pipeline.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   mem_we      CPU write enable
//   mem_addr    CPU address (read every cycle, write when mem_we)
//   mem_data    CPU write data
//   mem_in      read data to CPU, READ_LATENCY edges after the address
//   busy        high while the clear sweep is running
//   load_valid  preload word offered
//   load_addr   preload address
//   load_data   preload word
//   load_ready  preload word accepted this cycle when high with load_valid
module memory_responder #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic                  busy,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   clr_cnt_reg;
  logic                    busy_reg;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  logic [DATA_WIDTH-1:0]   ram [DEPTH];
  // pipe_reg[0] is the RAM output register; higher indices are plain delay stages.
  logic [DATA_WIDTH-1:0]   pipe_reg [READ_LATENCY];

  // Clear sequencer: walks the counter through every address once, then
  // drops busy on the edge that writes the last location.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
      busy_reg    <= 1'b1;
    end else if (state_reg == ST_CLEAR) begin
      clr_cnt_reg <= clr_cnt_reg + ADDR_ONE;
      if (clr_cnt_reg == LAST_ADDR) begin
        state_reg <= ST_READY;
        busy_reg  <= 1'b0;
      end
    end
  end

  assign busy = busy_reg;

  // The CPU write owns the single write port, so the loader is only
  // accepted in ready cycles without a CPU write.
  assign load_ready = (state_reg == ST_READY) & ~mem_we & ~rst;

  // Single write port shared by the clear sweep, CPU writes and preload.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = mem_addr;
    wr_data = mem_data;
    if (!rst) begin
      if (state_reg == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_reg;
        wr_data = CLEAR_VALUE;
      end else if (mem_we) begin
        wr_en   = 1'b1;
      end else if (load_valid && load_ready) begin
        wr_en   = 1'b1;
        wr_addr = load_addr;
        wr_data = load_data;
      end
    end
  end

  // Read-first RAM: a read that coincides with a write to the same address
  // returns the previous contents. The output register is forced to zero
  // during reset and clear so mem_in never shows stale data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
    if (rst || state_reg == ST_CLEAR) begin
      pipe_reg[0] <= '0;
    end else begin
      pipe_reg[0] <= ram[mem_addr];
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_reg[gi] <= '0;
        end else begin
          pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign mem_in = pipe_reg[READ_LATENCY-1];

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
//   Drives four memory_responder instances (READ_LATENCY 1..4) with the same
//   stimulus. A word-array model of the memory plus a short history of read
//   results gives the expected mem_in for every latency; busy and load_ready
//   follow from the model's clear progress. Directed sequences pin the model
//   with literal values, then a randomized phase runs against the model.
module tb_memory_responder;

  logic        clk;
  logic        rst;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data;
  logic        load_valid;
  logic [5:0]  load_addr;
  logic [15:0] load_data;

  logic [15:0] mem_in_w     [4];
  logic        busy_w       [4];
  logic        load_ready_w [4];

  int n_cmp  = 0;
  int n_fail = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      memory_responder #(
        .ADDR_WIDTH   (6),
        .DATA_WIDTH   (16),
        .READ_LATENCY (gi + 1),
        .CLEAR_VALUE  (16'h0000)
      ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_in     (mem_in_w[gi]),
        .busy       (busy_w[gi]),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready_w[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem  [64];
  logic [15:0] m_hist [4];   // m_hist[k] = read result that a latency-(k+1) port shows now
  logic [15:0] m_rd;
  bit          m_busy   = 1'b1;
  int          m_cnt    = 0;  // number of words cleared so far
  bit          checking = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy   = 1'b1;
      m_cnt    = 0;
      checking = 1'b1;
      for (int i = 0; i < 4; i++) m_hist[i] = 16'h0000;
    end else begin
      if (m_busy) begin
        m_rd = 16'h0000;
        m_mem[m_cnt[5:0]] = 16'h0000;
        m_cnt++;
        if (m_cnt == 64) begin
          m_busy = 1'b0;
          m_cnt  = 0;
        end
      end else begin
        m_rd = m_mem[mem_addr];
        if (mem_we)          m_mem[mem_addr]  = mem_data;
        else if (load_valid) m_mem[load_addr] = load_data;
      end
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_rd;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("mem_in_L%0d", i + 1), 32'(mem_in_w[i]), 32'(m_hist[i]));
        check($sformatf("busy_L%0d", i + 1), 32'(busy_w[i]), 32'(m_busy));
        check($sformatf("load_ready_L%0d", i + 1), 32'(load_ready_w[i]),
              32'(!m_busy && !mem_we && !rst));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string name);
    int cnt;
    cnt = 0;
    while (busy_w[1] === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    check(name, 32'(cnt), 32'd64);
    $display("clear %s: busy for %0d cycles", name, cnt);
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    mem_we   = 1'b1;
    mem_addr = a;
    mem_data = d;
    tick();
    mem_we   = 1'b0;
    $display("write addr=0x%02h data=0x%04h", a, d);
  endtask

  task automatic read_check(input string name, input logic [5:0] a, input logic [15:0] exp);
    mem_we     = 1'b0;
    load_valid = 1'b0;
    mem_addr   = a;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("%s_L%0d", name, k), 32'(mem_in_w[k-1]), 32'(exp));
    end
    $display("read  addr=0x%02h expect=0x%04h (%s)", a, exp, name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int i;
    int cyc;
    int acc_busy;
    int ready_cyc;
    int busy_cyc;
    bit acc;

    rst = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_data = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0;
    tick();
    tick();
    rst = 1'b0;
    wait_clear("reset_clear");

    read_check("clr_a0", 6'd0, 16'h0000);
    read_check("clr_a8", 6'd8, 16'h0000);
    read_check("clr_a63", 6'd63, 16'h0000);

    // Latency: data appears exactly READ_LATENCY edges after the address.
    wr(6'h08, 16'hBEEF);
    mem_addr = 6'h00;
    for (int k = 0; k < 4; k++) tick();
    mem_addr = 6'h08;
    for (int k = 1; k <= 4; k++) begin
      tick();
      for (int j = 0; j < 4; j++) begin
        if (k == j + 1)  check($sformatf("lat_hit_L%0d", j + 1), 32'(mem_in_w[j]), 32'h0000BEEF);
        else if (k == j) check($sformatf("lat_early_L%0d", j + 1), 32'(mem_in_w[j]), 32'h00000000);
      end
    end
    $display("read  addr=0x08 latency sweep expect=0xBEEF");

    // CPU write and preload collide on addr 5: CPU wins, loader retries.
    mem_we = 1'b1; mem_addr = 6'd5; mem_data = 16'h1234;
    load_valid = 1'b1; load_addr = 6'd5; load_data = 16'hAAAA;
    #1;
    check("collide_ready", 32'(load_ready_w[1]), 32'd0);
    tick();
    mem_we = 1'b0;
    #1;
    check("retry_ready", 32'(load_ready_w[1]), 32'd1);
    tick();
    load_valid = 1'b0;
    check("collide_cpu_word", 32'(mem_in_w[0]), 32'h00001234);
    $display("collide addr=0x05 cpu=0x1234 then load=0xAAAA");
    read_check("collide_load_word", 6'd5, 16'hAAAA);

    // Read-during-write returns the old word.
    wr(6'd3, 16'h0001);
    mem_we = 1'b1; mem_addr = 6'd3; mem_data = 16'h0002;
    tick();
    mem_we = 1'b0;
    check("rdw_old", 32'(mem_in_w[0]), 32'h00000001);
    $display("rdw   addr=0x03 old=0x0001 new=0x0002");
    read_check("rdw_new", 6'd3, 16'h0002);

    // Preload burst offered from the start of a clear.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i = 0; cyc = 0; acc_busy = 0; ready_cyc = 0; busy_cyc = 0;
    while (i < 8 && cyc < 300) begin
      load_valid = 1'b1;
      load_addr  = 6'(8 + i);
      load_data  = 16'(16'h0100 + i);
      #1;
      acc = load_ready_w[1];
      if (busy_w[1]) begin
        busy_cyc++;
        if (acc) acc_busy++;
      end else begin
        ready_cyc++;
      end
      tick();
      if (acc) i++;
      cyc++;
    end
    load_valid = 1'b0;
    check("preload_accept_busy", 32'(acc_busy), 32'd0);
    check("preload_busy_cycles", 32'(busy_cyc), 32'd64);
    check("preload_ready_cycles", 32'(ready_cyc), 32'd8);
    $display("preload burst: %0d busy cycles, %0d ready cycles", busy_cyc, ready_cyc);
    for (int k = 0; k < 8; k++)
      read_check($sformatf("preload_%0d", k), 6'(8 + k), 16'(16'h0100 + k));

    // Reset with reads in flight, then reset again at clear counter 20.
    mem_addr = 6'd8;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++)
      check($sformatf("flush_L%0d", k + 1), 32'(mem_in_w[k]), 32'h0);
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("reset_at_20");

    // Randomized traffic, occasional resets.
    for (int n = 0; n < 1000; n++) begin
      rst        = ($urandom_range(0, 399) == 0);
      mem_we     = ($urandom_range(0, 3) == 0);
      mem_addr   = 6'($urandom_range(0, 63));
      mem_data   = 16'($urandom_range(0, 65535));
      load_valid = 1'($urandom_range(0, 1));
      load_addr  = 6'($urandom_range(0, 63));
      load_data  = 16'($urandom_range(0, 65535));
      tick();
    end
    rst = 1'b0; mem_we = 1'b0; load_valid = 1'b0;
    $display("random phase: 1000 cycles");
    for (int k = 0; k < 6; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
